pipeline_hazard_ctl: RTL and testbench

Hazard and stall scheduler for the 5-stage RISC-V pipeline. It sits beside the decode/control path and takes the register indices and control bits already piped through ID, EX, MEM and WB. From those it drives the operand-forwarding selects, per-stage stall and flush lines, and a wait-state FSM that freezes the pipeline while the data memory has not acknowledged a MEM-stage access. It also exposes a sticky timeout error flag and a saturating stall-cycle counter for debug.

---
 rtl/pipeline_hazard_ctl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctl.sv
// Hazard and stall scheduler for the 5-stage pipeline: operand forwarding,
// load-use and data-memory wait stalls, branch flushes, timeout flag and a
// saturating stall-cycle counter.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_RUN  | normal flow; a MEM access without ready starts a wait
//   S_WAIT | pipeline frozen until the data memory signals ready
//   S_ERR  | memory never answered; pipeline frozen until reset
module pipeline_hazard_ctl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_rs1_d,
  input  logic [4:0]       i_rs2_d,
  input  logic [4:0]       i_rs1_e,
  input  logic [4:0]       i_rs2_e,
  input  logic [4:0]       i_rd_e,
  input  logic [4:0]       i_rd_m,
  input  logic [4:0]       i_rd_w,
  input  logic [1:0]       i_result_src_e,
  input  logic             i_reg_write_m,
  input  logic             i_reg_write_w,
  input  logic             i_pc_src_e,
  input  logic             i_mem_req_m,
  input  logic             i_mem_ready,
  output logic [1:0]       o_fwd_a_e,
  output logic [1:0]       o_fwd_b_e,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_stall_m,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic             o_flush_w,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              lw_stall;
  logic              mem_stall;
  logic              any_stall;

  // Forwarding selects; the younger MEM result takes precedence over WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (i_reg_write_m && i_rd_m != 5'd0 && i_rd_m == i_rs1_e)
      fwd_a = 2'b10;
    else if (i_reg_write_w && i_rd_w != 5'd0 && i_rd_w == i_rs1_e)
      fwd_a = 2'b01;
    if (i_reg_write_m && i_rd_m != 5'd0 && i_rd_m == i_rs2_e)
      fwd_b = 2'b10;
    else if (i_reg_write_w && i_rd_w != 5'd0 && i_rd_w == i_rs2_e)
      fwd_b = 2'b01;
  end

  // Load-use detection and memory stall derived from the current state.
  always_comb begin
    lw_stall = (i_result_src_e == 2'b01) && (i_rd_e != 5'd0) &&
               ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
    mem_stall = 1'b0;
    case (state)
      S_RUN:   mem_stall = i_mem_req_m & ~i_mem_ready;
      S_WAIT:  mem_stall = ~i_mem_ready;
      S_ERR:   mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Stall/flush priority: reset, then memory freeze, then load-use/redirect.
  // During a memory freeze a taken branch is held in EX, so no D/E flush.
  always_comb begin
    o_fwd_a_e = fwd_a;
    o_fwd_b_e = fwd_b;
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_stall_e = 1'b0;
    o_stall_m = 1'b0;
    o_flush_d = 1'b0;
    o_flush_e = 1'b0;
    o_flush_w = 1'b0;
    if (i_rst) begin
      o_fwd_a_e = 2'b00;
      o_fwd_b_e = 2'b00;
      o_flush_d = 1'b1;
      o_flush_e = 1'b1;
      o_flush_w = 1'b1;
    end else if (mem_stall) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_stall_e = 1'b1;
      o_stall_m = 1'b1;
      o_flush_w = 1'b1;
    end else begin
      o_stall_f = lw_stall;
      o_stall_d = lw_stall;
      o_flush_d = i_pc_src_e;
      o_flush_e = lw_stall | i_pc_src_e;
    end
  end

  assign any_stall = o_stall_f | o_stall_d | o_stall_e | o_stall_m;

  // Wait-state FSM with consecutive-stall timer and sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_RUN;
      wait_cnt      <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      case (state)
        S_RUN, S_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt == WAIT_LAST) begin
              state         <= S_ERR;
              o_mem_timeout <= 1'b1;
              wait_cnt      <= '0;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end else begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end
        end
        S_ERR: begin
          state    <= S_ERR;
          wait_cnt <= '0;
        end
        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which any stage was held.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_stall_cycles <= '0;
    else if (any_stall && o_stall_cycles != {CNT_W{1'b1}})
      o_stall_cycles <= o_stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Directed bench for pipeline_hazard_ctl: a vector table for the
// combinational hazard logic plus hand sequences for the wait FSM.
module tb_pipeline_hazard_ctl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [4:0]       i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w;
  logic [1:0]       i_result_src_e;
  logic             i_reg_write_m, i_reg_write_w, i_pc_src_e, i_mem_req_m, i_mem_ready;
  logic [1:0]       o_fwd_a_e, o_fwd_b_e;
  logic             o_stall_f, o_stall_d, o_stall_e, o_stall_m;
  logic             o_flush_d, o_flush_e, o_flush_w, o_mem_timeout;
  logic [CNT_W-1:0] o_stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_cnt;

  pipeline_hazard_ctl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rs1_d(i_rs1_d), .i_rs2_d(i_rs2_d), .i_rs1_e(i_rs1_e), .i_rs2_e(i_rs2_e),
    .i_rd_e(i_rd_e), .i_rd_m(i_rd_m), .i_rd_w(i_rd_w),
    .i_result_src_e(i_result_src_e),
    .i_reg_write_m(i_reg_write_m), .i_reg_write_w(i_reg_write_w),
    .i_pc_src_e(i_pc_src_e), .i_mem_req_m(i_mem_req_m), .i_mem_ready(i_mem_ready),
    .o_fwd_a_e(o_fwd_a_e), .o_fwd_b_e(o_fwd_b_e),
    .o_stall_f(o_stall_f), .o_stall_d(o_stall_d), .o_stall_e(o_stall_e), .o_stall_m(o_stall_m),
    .o_flush_d(o_flush_d), .o_flush_e(o_flush_e), .o_flush_w(o_flush_w),
    .o_mem_timeout(o_mem_timeout), .o_stall_cycles(o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] res_src;
    logic       rw_m, rw_w, pc_src;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_fd, flush_d, flush_e;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  task automatic chk_ctl(input string nm, input logic [6:0] exp);
    chk(nm, {25'd0, o_stall_f, o_stall_d, o_stall_e, o_stall_m,
             o_flush_d, o_flush_e, o_flush_w}, {25'd0, exp});
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_in();
    i_rs1_d = 0; i_rs2_d = 0; i_rs1_e = 0; i_rs2_e = 0;
    i_rd_e = 0; i_rd_m = 0; i_rd_w = 0; i_result_src_e = 2'b00;
    i_reg_write_m = 0; i_reg_write_w = 0; i_pc_src_e = 0;
    i_mem_req_m = 0; i_mem_ready = 0;
  endtask

  // One reset cycle with hazards present on the inputs; reset must mask them.
  task automatic do_reset();
    clear_in();
    i_rst = 1'b1;
    i_rd_m = 5; i_reg_write_m = 1; i_rs1_e = 5; i_rs2_e = 5;
    i_result_src_e = 2'b01; i_rd_e = 3; i_rs1_d = 3; i_pc_src_e = 1;
    @(negedge i_clk);
    chk_ctl("reset_ctl", 7'b0000111);
    chk("reset_fwd", {28'd0, o_fwd_a_e, o_fwd_b_e}, 32'd0);
    step();
    i_rst = 1'b0;
    clear_in();
  endtask

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd5,  5'd0, 5'd0, 5'd5, 5'd5,  2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd0, 5'd0, 5'd5,  5'd0, 5'd0, 5'd0, 5'd5,  2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'd0, 5'd0, 5'd0,  5'd0, 5'd0, 5'd0, 5'd5,  2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'd0, 5'd0, 5'd0,  5'd9, 5'd0, 5'd9, 5'd9,  2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd0, 5'd0, 5'd3,  5'd3, 5'd0, 5'd3, 5'd3,  2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'd0, 5'd7, 5'd0,  5'd0, 5'd7, 5'd0, 5'd0,  2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{5'd0, 5'd7, 5'd0,  5'd0, 5'd7, 5'd0, 5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{5'd0, 5'd0, 5'd0,  5'd0, 5'd0, 5'd0, 5'd0,  2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'd7, 5'd0, 5'd0,  5'd0, 5'd7, 5'd0, 5'd0,  2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{5'd0, 5'd0, 5'd0,  5'd0, 5'd0, 5'd0, 5'd0,  2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{5'd7, 5'd0, 5'd0,  5'd0, 5'd7, 5'd0, 5'd0,  2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{5'd0, 5'd0, 5'd12, 5'd4, 5'd0, 5'd4, 5'd12, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{5'd0, 5'd0, 5'd0,  5'd6, 5'd0, 5'd6, 5'd0,  2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    clear_in();
    i_rst = 1'b1;
    step();
    do_reset();

    // Table-driven combinational checks, one vector per cycle, in S_RUN.
    @(negedge i_clk);
    chk("cnt_after_reset", {28'd0, o_stall_cycles}, 32'd0);
    chk("timeout_after_reset", {31'd0, o_mem_timeout}, 32'd0);
    exp_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      i_rs1_d = vecs[i].rs1_d; i_rs2_d = vecs[i].rs2_d;
      i_rs1_e = vecs[i].rs1_e; i_rs2_e = vecs[i].rs2_e;
      i_rd_e = vecs[i].rd_e; i_rd_m = vecs[i].rd_m; i_rd_w = vecs[i].rd_w;
      i_result_src_e = vecs[i].res_src;
      i_reg_write_m = vecs[i].rw_m; i_reg_write_w = vecs[i].rw_w;
      i_pc_src_e = vecs[i].pc_src;
      @(negedge i_clk);
      chk($sformatf("vec%0d_fwd", i), {28'd0, o_fwd_a_e, o_fwd_b_e},
          {28'd0, vecs[i].fwd_a, vecs[i].fwd_b});
      chk_ctl($sformatf("vec%0d_ctl", i),
              {vecs[i].stall_fd, vecs[i].stall_fd, 1'b0, 1'b0,
               vecs[i].flush_d, vecs[i].flush_e, 1'b0});
      if (vecs[i].stall_fd) exp_cnt++;
      step();
    end
    clear_in();
    @(negedge i_clk);
    chk("vec_stall_cnt", {28'd0, o_stall_cycles}, exp_cnt);

    // Load-use: one stalled cycle counts once.
    do_reset();
    i_result_src_e = 2'b01; i_rd_e = 7; i_rs2_d = 7;
    @(negedge i_clk);
    chk_ctl("lu_ctl", 7'b1100010);
    chk("lu_cnt_before", {28'd0, o_stall_cycles}, 32'd0);
    step();
    clear_in();
    @(negedge i_clk);
    chk_ctl("lu_released", 7'b0000000);
    chk("lu_cnt_after", {28'd0, o_stall_cycles}, 32'd1);

    // Memory wait of 3 cycles with a redirect arriving mid-wait.
    do_reset();
    i_mem_req_m = 1; i_mem_ready = 0;
    @(negedge i_clk);
    chk_ctl("mw_c1", 7'b1111001);
    step();
    i_mem_req_m = 0; i_pc_src_e = 1;
    @(negedge i_clk);
    chk_ctl("mw_c2_redirect_held", 7'b1111001);
    step();
    @(negedge i_clk);
    chk_ctl("mw_c3", 7'b1111001);
    step();
    i_mem_ready = 1;
    @(negedge i_clk);
    chk_ctl("mw_c4_ready_flush", 7'b0000110);
    step();
    clear_in();
    @(negedge i_clk);
    chk_ctl("mw_back_run", 7'b0000000);
    chk("mw_cnt", {28'd0, o_stall_cycles}, 32'd3);
    chk("mw_no_timeout", {31'd0, o_mem_timeout}, 32'd0);

    // Zero-wait access: no stall, no state change.
    do_reset();
    i_mem_req_m = 1; i_mem_ready = 1;
    @(negedge i_clk);
    chk_ctl("zw_c1", 7'b0000000);
    step();
    @(negedge i_clk);
    chk_ctl("zw_c2", 7'b0000000);
    step();
    clear_in();
    @(negedge i_clk);
    chk_ctl("zw_idle", 7'b0000000);
    chk("zw_cnt", {28'd0, o_stall_cycles}, 32'd0);

    // Timeout after MEM_TIMEOUT stalled cycles, sticky until reset.
    do_reset();
    i_mem_req_m = 1; i_mem_ready = 0;
    for (int c = 1; c <= MEM_TIMEOUT; c++) begin
      @(negedge i_clk);
      chk_ctl($sformatf("to_stall_c%0d", c), 7'b1111001);
      chk($sformatf("to_flag_c%0d", c), {31'd0, o_mem_timeout}, 32'd0);
      step();
    end
    i_mem_req_m = 0; i_mem_ready = 1;
    @(negedge i_clk);
    chk("to_flag_set", {31'd0, o_mem_timeout}, 32'd1);
    chk_ctl("to_err_stall", 7'b1111001);
    step();
    @(negedge i_clk);
    chk("to_flag_sticky", {31'd0, o_mem_timeout}, 32'd1);
    chk("to_cnt", {28'd0, o_stall_cycles}, 32'd5);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk_ctl("to_rst_ctl", 7'b0000111);
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_ctl("to_after_rst", 7'b0000000);
    chk("to_flag_cleared", {31'd0, o_mem_timeout}, 32'd0);
    chk("to_cnt_cleared", {28'd0, o_stall_cycles}, 32'd0);

    // Ready on the timeout boundary cycle wins: no error.
    do_reset();
    i_mem_req_m = 1; i_mem_ready = 0;
    for (int c = 1; c < MEM_TIMEOUT; c++) step();
    i_mem_ready = 1;
    @(negedge i_clk);
    chk_ctl("bd_ready_ctl", 7'b0000000);
    step();
    clear_in();
    @(negedge i_clk);
    chk("bd_no_timeout", {31'd0, o_mem_timeout}, 32'd0);
    chk_ctl("bd_run", 7'b0000000);

    // Reset in the middle of a wait returns to S_RUN.
    do_reset();
    i_mem_req_m = 1; i_mem_ready = 0;
    step();
    step();
    i_rst = 1'b1;
    @(negedge i_clk);
    chk_ctl("mr_rst_ctl", 7'b0000111);
    step();
    i_rst = 1'b0;
    i_mem_req_m = 0;
    @(negedge i_clk);
    chk_ctl("mr_run", 7'b0000000);
    chk("mr_cnt", {28'd0, o_stall_cycles}, 32'd0);

    // Stall counter saturates at all-ones.
    do_reset();
    i_result_src_e = 2'b01; i_rd_e = 9; i_rs1_d = 9;
    for (int c = 0; c < 15; c++) step();
    @(negedge i_clk);
    chk("sat_reach", {28'd0, o_stall_cycles}, 32'd15);
    for (int c = 0; c < 3; c++) step();
    @(negedge i_clk);
    chk("sat_hold", {28'd0, o_stall_cycles}, 32'd15);
    clear_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
